// File: rtl/tx_frame_builder.sv
// Measurement-to-frame serializer: wraps each accepted 32-bit count into SYNC/seq, value
// and optional checksum segments for a downstream word transmitter. Option: FRAME_CHECKSUM_EN.
module tx_frame_builder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_valid,
  input  logic [31:0] meas_value,
  output logic        meas_ready,
  output logic        tx_start,
  output logic [31:0] tx_word,
  output logic [2:0]  tx_bytes,
  input  logic        tx_busy,
  output logic        frame_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

`ifdef FRAME_CHECKSUM_EN
  localparam logic [1:0] LAST_SEG = 2'd2;
`else
  localparam logic [1:0] LAST_SEG = 2'd1;
`endif

  state_t      state, state_next;
  logic [1:0]  seg, seg_next;
  logic [7:0]  seq;
  logic [31:0] value_q;
  logic        accept;
  logic        load_word;
  logic [31:0] word_next;
  logic [2:0]  bytes_next;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_next;

  // Sum uses the pre-increment seq, which is exactly the seq this frame carries.
  assign csum_next = seq + meas_value[7:0] + meas_value[15:8]
                   + meas_value[23:16] + meas_value[31:24];
`endif

  assign accept     = meas_valid && (state == IDLE);
  assign frame_busy = (state != IDLE);
  assign meas_ready = (state == IDLE);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    seg_next   = seg;
    tx_start   = 1'b0;
    load_word  = 1'b0;
    unique case (state)
      IDLE: begin
        if (meas_valid) begin
          state_next = ISSUE;
          seg_next   = 2'd0;
          load_word  = 1'b1;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          state_next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (seg == LAST_SEG) begin
            state_next = IDLE;
          end else begin
            state_next = ISSUE;
            seg_next   = seg + 2'd1;
            load_word  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word for the segment about to be issued; seg 1 reads value_q, which is
  // only selected after the accept edge has latched it.
  always_comb begin
    word_next  = {16'h0000, seq, SYNC_BYTE};
    bytes_next = 3'd2;
    unique case (seg_next)
      2'd0: begin
        word_next  = {16'h0000, seq, SYNC_BYTE};
        bytes_next = 3'd2;
      end
      2'd1: begin
        word_next  = value_q;
        bytes_next = 3'd4;
      end
`ifdef FRAME_CHECKSUM_EN
      2'd2: begin
        word_next  = {24'h000000, csum_q};
        bytes_next = 3'd1;
      end
`endif
      default: begin
        word_next  = {16'h0000, seq, SYNC_BYTE};
        bytes_next = 3'd2;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      seg   <= 2'd0;
    end else begin
      state <= state_next;
      seg   <= seg_next;
    end
  end

  // NOTE: data registers are reset too, because tx_word/tx_bytes are visible
  // outputs with defined reset values and an aborted frame must not leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= 8'h00;
      value_q  <= 32'h0000_0000;
      tx_word  <= 32'h0000_0000;
      tx_bytes <= 3'd0;
    end else begin
      if (accept) value_q <= meas_value;
      if (tx_start && (seg == 2'd0)) seq <= seq + 8'h01;
      if (load_word) begin
        tx_word  <= word_next;
        tx_bytes <= bytes_next;
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
    end else if (accept) begin
      csum_q <= csum_next;
    end
  end
`endif

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench for tx_frame_builder with a simple downstream transmitter model
// (busy two cycles per byte); expected frames are built from hand-derived byte layouts.
module tb_tx_frame_builder;

`ifdef FRAME_CHECKSUM_EN
  localparam int NSEG   = 3;
  localparam int NBYTES = 7;
`else
  localparam int NSEG   = 2;
  localparam int NBYTES = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_valid = 1'b0;
  logic [31:0] meas_value = 32'h0;
  logic        meas_ready;
  logic        tx_start;
  logic [31:0] tx_word;
  logic [2:0]  tx_bytes;
  logic        tx_busy;
  logic        frame_busy;

  int checks = 0;
  int failures = 0;
  int ready_err = 0;

  logic       force_busy = 1'b0;
  int         busy_cnt;
  int         start_count = 0;
  logic [7:0] bytes_q[$];
  logic [34:0] segs_q[$];
  logic [7:0] exp_seq;

  tx_frame_builder #(.SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .meas_valid (meas_valid),
    .meas_value (meas_value),
    .meas_ready (meas_ready),
    .tx_start   (tx_start),
    .tx_word    (tx_word),
    .tx_bytes   (tx_bytes),
    .tx_busy    (tx_busy),
    .frame_busy (frame_busy)
  );

  always #5 clk = ~clk;

  assign tx_busy = force_busy | (busy_cnt != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 2 * int'(tx_bytes);
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && tx_start === 1'b1) begin
      for (int i = 0; i < int'(tx_bytes); i++) bytes_q.push_back(tx_word[8*i +: 8]);
      segs_q.push_back({tx_bytes, tx_word});
      start_count++;
    end
  end

  function automatic logic [55:0] frame_bytes(input logic [7:0] s, input logic [31:0] v);
    logic [7:0] c;
    c = s + v[7:0] + v[15:8] + v[23:16] + v[31:24];
    return {c, v, s, 8'hA5};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (frame_busy !== 1'b0 && n < 2000) begin
      if (meas_ready !== 1'b0) ready_err++;
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout frame_busy=%b", frame_busy);
    end
  endtask

  task automatic send(input logic [31:0] v);
    meas_valid = 1'b1;
    meas_value = v;
    @(posedge clk);
    @(negedge clk);
    meas_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({meas_ready, frame_busy, tx_start} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl got ready/busy/start=%b want 100", {meas_ready, frame_busy, tx_start});
    end
    checks++;
    if (tx_word !== 32'h0 || tx_bytes !== 3'd0) begin
      failures++;
      $display("FAIL reset_word got word=%h bytes=%0d want 0/0", tx_word, tx_bytes);
    end
    rst_n = 1'b1;
    exp_seq = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int b = bytes_q.size();
    int sb = segs_q.size();
    logic [55:0] e = frame_bytes(8'h00, 32'h12345678);
    meas_valid = 1'b1;
    meas_value = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    meas_valid = 1'b0;
    meas_value = 32'hFFFF_0000;
    checks++;
    if (tx_start !== 1'b1) begin
      failures++; $display("FAIL basic_latency tx_start=%b want 1", tx_start);
    end
    checks++;
    if (tx_word !== 32'h0000_00A5 || tx_bytes !== 3'd2) begin
      failures++; $display("FAIL basic_s0 got %h/%0d want 000000a5/2", tx_word, tx_bytes);
    end
    checks++;
    if (meas_ready !== 1'b0 || frame_busy !== 1'b1) begin
      failures++; $display("FAIL basic_busy ready=%b busy=%b want 0/1", meas_ready, frame_busy);
    end
    wait_idle();
    checks++;
    if (segs_q.size() != sb + NSEG) begin
      failures++; $display("FAIL basic_nseg got %0d want %0d", segs_q.size() - sb, NSEG);
    end else begin
      checks++;
      if (segs_q[sb] !== {3'd2, 32'h0000_00A5}) begin
        failures++; $display("FAIL basic_seg0 got %h", segs_q[sb]);
      end
      checks++;
      if (segs_q[sb+1] !== {3'd4, 32'h12345678}) begin
        failures++; $display("FAIL basic_seg1 got %h", segs_q[sb+1]);
      end
`ifdef FRAME_CHECKSUM_EN
      checks++;
      if (segs_q[sb+2] !== {3'd1, 32'h0000_0014}) begin
        failures++; $display("FAIL basic_seg2 got %h want 1/00000014", segs_q[sb+2]);
      end
      checks++;
      if (tx_word !== 32'h0000_0014) begin
        failures++; $display("FAIL basic_hold got %h want 00000014", tx_word);
      end
`else
      checks++;
      if (tx_word !== 32'h12345678) begin
        failures++; $display("FAIL basic_hold got %h want 12345678", tx_word);
      end
`endif
    end
    checks++;
    if (bytes_q.size() != b + NBYTES) begin
      failures++; $display("FAIL basic_len got %0d want %0d", bytes_q.size() - b, NBYTES);
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        checks++;
        if (bytes_q[b+i] !== e[8*i +: 8]) begin
          failures++; $display("FAIL basic_byte%0d got %h want %h", i, bytes_q[b+i], e[8*i +: 8]);
        end
      end
    end
    exp_seq++;
  endtask

  task automatic test_busy_hold();
    int sc = start_count;
    int hits = 0;
    force_busy = 1'b1;
    meas_valid = 1'b1;
    meas_value = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    meas_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_start !== 1'b0) hits++;
      @(negedge clk);
    end
    checks++;
    if (hits != 0 || start_count != sc) begin
      failures++; $display("FAIL busy_hold_nostart got %0d pulses want 0", hits);
    end
    force_busy = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b1 || tx_word !== {16'h0, exp_seq, 8'hA5}) begin
      failures++; $display("FAIL busy_release start=%b word=%h want 1/%h", tx_start, tx_word, {16'h0, exp_seq, 8'hA5});
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || start_count != sc + 1) begin
      failures++; $display("FAIL busy_single start=%b count=%0d want 0/1", tx_start, start_count - sc);
    end
    wait_idle();
    checks++;
    if (start_count != sc + NSEG) begin
      failures++; $display("FAIL busy_total got %0d want %0d", start_count - sc, NSEG);
    end
    exp_seq++;
  endtask

  task automatic test_hold_valid();
    int b = bytes_q.size();
    logic [55:0] ea = frame_bytes(exp_seq, 32'hDEADBEEF);
    logic [55:0] eb = frame_bytes(exp_seq + 8'h01, 32'h0BADF00D);
    meas_valid = 1'b1;
    meas_value = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    meas_value = 32'h0BADF00D;
    wait_idle();
    checks++;
    if (meas_ready !== 1'b1) begin
      failures++; $display("FAIL hold_ready got %b want 1", meas_ready);
    end
    @(posedge clk);
    @(negedge clk);
    meas_valid = 1'b0;
    checks++;
    if (frame_busy !== 1'b1) begin
      failures++; $display("FAIL hold_second_accept busy=%b want 1", frame_busy);
    end
    wait_idle();
    checks++;
    if (bytes_q.size() != b + 2 * NBYTES) begin
      failures++; $display("FAIL hold_len got %0d want %0d", bytes_q.size() - b, 2 * NBYTES);
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        checks++;
        if (bytes_q[b+i] !== ea[8*i +: 8] || bytes_q[b+NBYTES+i] !== eb[8*i +: 8]) begin
          failures++;
          $display("FAIL hold_byte%0d got %h/%h want %h/%h", i, bytes_q[b+i], bytes_q[b+NBYTES+i], ea[8*i +: 8], eb[8*i +: 8]);
        end
      end
    end
    exp_seq = exp_seq + 8'h02;
  endtask

  task automatic test_reset_mid();
    int sc = start_count;
    int n = 0;
    int b;
    logic [55:0] e = frame_bytes(8'h00, 32'hFFFFFFFF);
    meas_valid = 1'b1;
    meas_value = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    meas_valid = 1'b0;
    while (start_count < sc + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++; $display("FAIL rstmid_s1 timeout starts=%0d want 2", start_count - sc);
    end
    @(negedge clk);
    checks++;
    if (frame_busy !== 1'b1 || tx_busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_waitlo busy=%b tx_busy=%b want 1/1", frame_busy, tx_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({meas_ready, frame_busy, tx_start} !== 3'b100 || tx_word !== 32'h0 || tx_bytes !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_outputs ready/busy/start=%b word=%h bytes=%0d want 100/0/0", {meas_ready, frame_busy, tx_start}, tx_word, tx_bytes);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_seq = 8'h00;
    @(negedge clk);
    checks++;
    if (start_count != sc + 2) begin
      failures++; $display("FAIL rstmid_aborted got %0d starts want 2", start_count - sc);
    end
    b = bytes_q.size();
    sc = start_count;
    send(32'hFFFFFFFF);
    checks++;
    if (start_count != sc + NSEG || bytes_q.size() != b + NBYTES) begin
      failures++; $display("FAIL maxval_len starts=%0d bytes=%0d want %0d/%0d", start_count - sc, bytes_q.size() - b, NSEG, NBYTES);
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        checks++;
        if (bytes_q[b+i] !== e[8*i +: 8]) begin
          failures++; $display("FAIL maxval_byte%0d got %h want %h", i, bytes_q[b+i], e[8*i +: 8]);
        end
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (start_count != sc + NSEG || frame_busy !== 1'b0) begin
      failures++; $display("FAIL maxval_idle starts=%0d busy=%b want %0d/0", start_count - sc, frame_busy, NSEG);
    end
    exp_seq++;
  endtask

  task automatic test_seq_wrap();
    int b;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ready_err = 0;
    for (int i = 0; i < 257; i++) begin
      b = bytes_q.size();
      send(32'h0101_0101 * i);
      checks++;
      if (bytes_q.size() != b + NBYTES) begin
        failures++; $display("FAIL wrap_len frame %0d got %0d want %0d", i, bytes_q.size() - b, NBYTES);
      end else if (bytes_q[b+1] !== 8'(i)) begin
        failures++; $display("FAIL wrap_seq frame %0d got %h want %h", i, bytes_q[b+1], 8'(i));
      end
    end
    checks++;
    if (ready_err != 0) begin
      failures++; $display("FAIL wrap_ready_low got %0d busy cycles with ready=1 want 0", ready_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_hold();
    test_hold_valid();
    test_reset_mid();
    test_seq_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_frame_builder.md
TX_FRAME_BUILDER -- requirements
Module: tx_frame_builder

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the first byte of every frame.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-004 The block SHALL have port meas_valid, input, 1, upstream measurement offer.
REQ-005 The block SHALL have port meas_value, input, 32, measured count, sampled on accept.
REQ-006 The block SHALL have port meas_ready, output, 1, high when the block can accept a measurement.
REQ-007 The block SHALL have port tx_start, output, 1, one-cycle request to the downstream word transmitter.
REQ-008 The block SHALL have port tx_word, output, 32, word to send, LSB byte sent first.
REQ-009 The block SHALL have port tx_bytes, output, 3, number of low bytes of tx_word to send (1..4).
REQ-010 The block SHALL have port tx_busy, input, 1, downstream busy; goes high the cycle after an accepted tx_start, low when all bytes are sent.
REQ-011 The block SHALL have port frame_busy, output, 1, high from accept until the frame's last segment completes.

Function
REQ-012 Accept SHALL occur on a rising clk edge with meas_valid=1 and meas_ready=1; meas_value is latched, meas_ready drops the next cycle.
REQ-013 meas_ready SHALL be 1 only in state Idle; no second measurement is buffered.
REQ-014 Each frame SHALL be sent as three segments in order: S0 tx_word={16'h0, seq, SYNC_BYTE}, tx_bytes=2; S1 tx_word=latched value, tx_bytes=4; S2 tx_word={24'h0, csum}, tx_bytes=1.
REQ-015 seq SHALL be an 8-bit frame counter, value used in the frame is the pre-increment value, incremented when S0 is issued, wrapping 8'hFF -> 8'h00.
REQ-016 csum SHALL be the 8-bit sum modulo 256 of seq and the four bytes of the latched value (SYNC_BYTE excluded).
REQ-017 The state machine SHALL have states Idle, Issue, WaitHi, WaitLo plus a 2-bit segment index.
REQ-018 Idle -> Issue on accept, segment index set to 0.
REQ-019 Issue: if tx_busy=0, tx_start=1 for exactly this cycle and -> WaitHi; if tx_busy=1, no pulse, remain in Issue.
REQ-020 WaitHi: remain until tx_busy=1, then -> WaitLo.
REQ-021 WaitLo: remain until tx_busy=0; then if last segment -> Idle, else increment segment index and -> Issue.
REQ-022 tx_word and tx_bytes SHALL be valid in the tx_start cycle and held until the next Issue cycle or reset.
REQ-023 Minimum latency SHALL be: accept at edge N, tx_start high in cycle N+1.
REQ-024 frame_busy SHALL equal (state != Idle); meas_ready SHALL equal its inverse.
REQ-025 meas_value changes while not accepting SHALL have no effect.

Reset
REQ-026 On rst_n=0, at any time including mid-frame, the block SHALL immediately enter Idle, abort the frame, and set seq=0, tx_start=0, tx_word=0, tx_bytes=0, frame_busy=0, meas_ready=1.
REQ-027 After rst_n rises the first accept SHALL produce a frame with seq=8'h00.

Configuration
REQ-028 With macro FRAME_CHECKSUM_EN defined, frames SHALL contain S0, S1, S2 as in REQ-014 (7 bytes).
REQ-029 Without FRAME_CHECKSUM_EN, S2 SHALL be omitted, S1 is the last segment (6 bytes), and no checksum logic is built.

Verification
REQ-030 After reset, value 32'h12345678 offered, tx_busy model idle -> segments {16'h0,8'h00,8'hA5}/2, 32'h12345678/4, 32'h14/1; byte stream A5 00 78 56 34 12 14.
REQ-031 tx_busy held high 20 cycles when S0 would issue -> no tx_start until tx_busy=0, then exactly one one-cycle pulse.
REQ-032 256 consecutive frames -> seq bytes 00..FF then 00 on frame 257; meas_ready low throughout each frame.
REQ-033 meas_valid held high with new value during frame -> ignored until Idle, then accepted; earlier value's frame unchanged.
REQ-034 rst_n low during WaitLo of S1 -> all outputs at reset values in the same cycle; next frame carries seq 00.
REQ-035 Build without FRAME_CHECKSUM_EN, value 32'hFFFFFFFF -> stream A5 00 FF FF FF FF, Idle after S1, no third tx_start.
